apb_reg_slave: RTL and testbench
================================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the PWDATA/PRDATA width.
REQ-002 Parameter DEPTH, default 64, SHALL set the register-file entries at addresses 0x00..DEPTH-1.
REQ-003 Parameter RESET_WAIT, default 0, SHALL set the reset value of WAIT_CFG.
REQ-004 Port PCLK, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port PRST, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port PSEL, input, 1: slave select from the APB master.
REQ-007 Port PENABLE, input, 1: access-phase indicator.
REQ-008 Port PWRITE, input, 1: 1 = write, 0 = read.
REQ-009 Port PADDR, input, 8: byte address (lower 8 bits of the bus address).
REQ-010 Port PWDATA, input, DATA_W: write data.
REQ-011 Port PRDATA, output, DATA_W: read data.
REQ-012 Port PREADY, output, 1: transfer completion.
REQ-013 Port PSLVERR, output, 1: error response, valid only while PREADY=1.

Function
REQ-014 The block SHALL use the states IDLE, SETUP and ACCESS.
REQ-015 IDLE->SETUP SHALL occur on PSEL=1, PENABLE=0.
- PADDR and PWRITE are captured.
- The wait counter is loaded with WAIT_CFG[3:0].
REQ-016 SETUP->ACCESS SHALL occur unconditionally on the next edge.
REQ-017 In ACCESS:
- Each cycle with counter≠0 SHALL decrement the counter, with PREADY=0.
- With counter=0, PREADY SHALL be 1 (combinational), and the state SHALL go to IDLE on that edge.
- WAIT_CFG=N therefore gives N wait cycles; N=0 gives zero-wait.
REQ-018 A write SHALL commit only on the edge where PSEL=1, PENABLE=1, PREADY=1 and PSLVERR=0.
REQ-019 PRDATA SHALL carry the addressed value while PREADY=1 on a read, and 0 at all other times.
REQ-020 Address map:
- 0x00..DEPTH-1: read/write registers.
- 0xF0: WAIT_CFG, read/write, bits [3:0] used, upper bits read 0.
- 0xF1: XFER_CNT, read-only.
- Any other address: unmapped.
REQ-021 PSLVERR SHALL be 1 with PREADY=1 for:
- an unmapped access (read returns 0, no state change);
- a write to XFER_CNT (value unchanged).
REQ-022 XFER_CNT SHALL increment by 1 on each completed non-error transfer and wrap 0xFF->0x00.
REQ-023 A WAIT_CFG write SHALL take effect from the next transfer's SETUP, never the current one.
REQ-024 If PSEL drops during ACCESS before PREADY, the block SHALL return to IDLE: no write, no XFER_CNT increment.
REQ-025 Protocol violation (PSEL=1, PENABLE=1 seen in IDLE): the block SHALL respond PREADY=1, PSLVERR=1 in the same cycle, with no state change.
REQ-026 Captured PADDR/PWRITE SHALL be used throughout ACCESS; bus changes after SETUP SHALL be ignored.

Reset
REQ-027 While PRST=0 the block SHALL force:
- state IDLE;
- PREADY=0, PSLVERR=0, PRDATA=0;
- all registers 0, XFER_CNT=0, WAIT_CFG=RESET_WAIT.
REQ-028 A reset asserted mid-transfer SHALL abort the transfer with no write committed.

Structure
REQ-029 State encodings, the WAIT_CFG/XFER_CNT addresses and the 4-bit wait width SHALL live in the shared APB package used by apb_master.
REQ-030 The register array and its read mux SHALL be one sub-module, apb_regfile (write port and asynchronous read port).

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Zero-wait write then read: WAIT_CFG=0, write 0xA5 to 0x10, read 0x10 -> PREADY high in the first ACCESS cycle, PRDATA=0xA5, XFER_CNT=2.
- Wait states: write 3 to 0xF0, then read 0x10 -> exactly 3 ACCESS cycles with PREADY=0, then PREADY=1 with PRDATA=0xA5.
- Errors:
  - read 0x80 -> PSLVERR=1, PRDATA=0;
  - write 0x55 to 0xF1 -> PSLVERR=1, XFER_CNT unchanged.
- XFER_CNT wrap: 256 successful transfers from reset -> XFER_CNT reads 0x00 on the 257th transfer, which is a read.
- Abort: WAIT_CFG=5, write 0x3C to 0x20, drop PSEL after 2 ACCESS cycles -> 0x20 still 0.
- Async reset: PRST low mid-wait -> outputs 0 immediately, registers 0, and WAIT_CFG back to RESET_WAIT.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared APB definitions used by the APB master and the register slave.
// Holds the bus-side state encoding, the control-register addresses and the
// width of the wait-state counter so both ends of the bus agree on them.
// No ports (package).
// ---------------------------------------------------------------------------
package apb_pkg;

    // Transfer phases as seen by a slave (and tracked by the master)
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Wait-state counter width; WAIT_CFG uses exactly this many bits
    localparam int WAIT_W = 4;

    // Transfer counter width; it wraps naturally at 2**XFER_CNT_W
    localparam int XFER_CNT_W = 8;

    // Control register addresses, placed above the register-file window
    localparam logic [7:0] ADDR_WAIT_CFG = 8'hF0;
    localparam logic [7:0] ADDR_XFER_CNT = 8'hF1;

endpackage

// File: rtl/apb_regfile.sv
// ---------------------------------------------------------------------------
// apb_regfile
// General-purpose register array behind the APB slave: one synchronous write
// port and one asynchronous (combinational) read port. Addresses at or
// beyond DEPTH are ignored on write and read back as zero.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, clears every entry
//   i_we     - write enable
//   i_waddr  - write byte address
//   i_wdata  - write data
//   i_raddr  - read byte address
//   o_rdata  - read data for i_raddr
// ---------------------------------------------------------------------------
module apb_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [7:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [7:0]        i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_hit;
    logic              w_rd_hit;

    // Range checks keep non-power-of-two depths from aliasing
    assign w_wr_hit = ({1'b0, i_waddr} < DEPTH_L);
    assign w_rd_hit = ({1'b0, i_raddr} < DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_wr_hit) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_hit ? r_mem[i_raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
// APB slave exposing a DEPTH-entry register file plus two control registers:
//   0xF0 WAIT_CFG - number of wait states inserted in ACCESS (4 bits, R/W)
//   0xF1 XFER_CNT - count of completed, error-free transfers (read-only)
// Unmapped accesses and writes to XFER_CNT complete with PSLVERR.
//
// Ports:
//   PCLK    - clock, all state updates on the rising edge
//   PRST    - asynchronous active-low reset
//   PSEL    - slave select
//   PENABLE - access-phase indicator
//   PWRITE  - 1 = write, 0 = read
//   PADDR   - byte address
//   PWDATA  - write data
//   PRDATA  - read data, zero unless a read is completing
//   PREADY  - transfer completion
//   PSLVERR - error response, meaningful only with PREADY
// ---------------------------------------------------------------------------
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 64,
    parameter int RESET_WAIT = 0
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam logic [WAIT_W-1:0] RESET_WAIT_V = RESET_WAIT[WAIT_W-1:0];
    localparam logic [8:0]        DEPTH_L      = 9'(DEPTH);

    apb_state_e             r_state;
    apb_state_e             w_next_state;
    logic [7:0]             r_addr;
    logic                   r_write;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [WAIT_W-1:0]      r_wait_cfg;
    logic [XFER_CNT_W-1:0]  r_xfer_cnt;

    logic                   w_ready;
    logic                   w_err;
    logic                   w_start;
    logic                   w_done;
    logic                   w_map_reg;
    logic                   w_map_cfg;
    logic                   w_map_cnt;
    logic                   w_bad_access;
    logic                   w_reg_we;
    logic [DATA_W-1:0]      w_reg_rdata;
    logic [DATA_W-1:0]      w_rd_val;

    // Decode is done on the captured address so mid-transfer bus changes
    // cannot redirect an access that already left SETUP
    assign w_map_reg    = ({1'b0, r_addr} < DEPTH_L);
    assign w_map_cfg    = (r_addr == ADDR_WAIT_CFG);
    assign w_map_cnt    = (r_addr == ADDR_XFER_CNT);
    assign w_bad_access = !(w_map_reg || w_map_cfg || w_map_cnt) ||
                          (r_write && w_map_cnt);

    // Next-state and handshake decode. A PSEL+PENABLE pair seen in IDLE is a
    // protocol violation: answered with an error in the same cycle while the
    // state stays put.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_err        = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_next_state = SETUP;
                    w_start      = 1'b1;
                end else if (PSEL && PENABLE) begin
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                w_ready = (r_wait_cnt == '0);
                w_err   = w_ready && w_bad_access;
                if (!PSEL || w_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A transfer counts as done only on a clean handshake in ACCESS
    assign w_done   = (r_state == ACCESS) && PSEL && PENABLE && w_ready && !w_err;
    assign w_reg_we = w_done && r_write && w_map_reg;

    // State register plus capture of the address phase, the wait counter,
    // and the two control registers
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wait_cnt <= '0;
            r_wait_cfg <= RESET_WAIT_V;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_addr     <= PADDR;
                r_write    <= PWRITE;
                r_wait_cnt <= r_wait_cfg;
            end else if ((r_state == ACCESS) && PSEL && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_done && r_write && w_map_cfg) begin
                r_wait_cfg <= PWDATA[WAIT_W-1:0];
            end
            if (w_done) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    apb_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRST),
        .i_we    (w_reg_we),
        .i_waddr (r_addr),
        .i_wdata (PWDATA),
        .i_raddr (r_addr),
        .o_rdata (w_reg_rdata)
    );

    // Read mux; control registers are zero-extended to the bus width
    always_comb begin
        w_rd_val = '0;
        if (w_map_reg) begin
            w_rd_val = w_reg_rdata;
        end else if (w_map_cfg) begin
            w_rd_val[WAIT_W-1:0] = r_wait_cfg;
        end else if (w_map_cnt) begin
            w_rd_val[XFER_CNT_W-1:0] = r_xfer_cnt;
        end
    end

    // Outputs are forced low while reset is held, even against a violating bus
    assign PREADY  = PRST && w_ready;
    assign PSLVERR = PRST && w_err;
    assign PRDATA  = (PREADY && !PSLVERR && (r_state == ACCESS) && !r_write) ?
                     w_rd_val : '0;

endmodule

// File: tb/tb_apb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_slave
// Directed bench for apb_reg_slave: drives APB transfers, compares responses
// against hand-computed values and prints a one-line summary.
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

    localparam int DW = 8;

    logic          PCLK;
    logic          PRST;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [7:0]    PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int testsRun;
    int testsFailed;

    apb_reg_slave #(
        .DATA_W     (DW),
        .DEPTH      (64),
        .RESET_WAIT (0)
    ) dut (
        .PCLK    (PCLK),
        .PRST    (PRST),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    // Free-running 10-time-unit clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives the setup phase, then raises PENABLE; returns in the SETUP state
    task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                 input logic [DW-1:0] wdata);
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
    endtask

    // Full transfer: counts ACCESS cycles spent with PREADY low, bounded
    task automatic apbXfer(input logic wr, input logic [7:0] addr,
                           input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                           output logic err, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        applyStimulus(wr, addr, wdata);
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge PCLK);
            #1;
            if (PREADY) begin
                done  = 1'b1;
                rdata = PRDATA;
                err   = PSLVERR;
            end else begin
                waits++;
            end
        end
        checkOutput("xferDone", 32'(done), 32'd1);
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    // Short reset pulse with the bus idle
    task automatic pulseReset();
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PRST    = 1'b0;
        @(negedge PCLK);
        PRST = 1'b1;
    endtask

    // Directed scenario sequence
    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            wt;

        testsRun    = 0;
        testsFailed = 0;
        PRST    = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = 8'h00;
        PWDATA  = '0;

        // Reset state, with a violating bus held to prove outputs are forced
        #12;
        checkOutput("rstPready", 32'(PREADY), 32'd0);
        checkOutput("rstSlverr", 32'(PSLVERR), 32'd0);
        checkOutput("rstPrdata", 32'(PRDATA), 32'd0);
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PRST    = 1'b1;

        // Zero-wait write then read
        apbXfer(1'b1, 8'h10, 8'hA5, rd, er, wt);
        checkOutput("zwWrWaits", 32'(wt), 32'd0);
        checkOutput("zwWrErr", 32'(er), 32'd0);
        apbXfer(1'b0, 8'h10, 8'h00, rd, er, wt);
        checkOutput("zwRdWaits", 32'(wt), 32'd0);
        checkOutput("zwRdData", 32'(rd), 32'hA5);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("zwXferCnt", 32'(rd), 32'd2);

        // WAIT_CFG write is itself zero-wait; the next transfer has 3 waits
        apbXfer(1'b1, 8'hF0, 8'h03, rd, er, wt);
        checkOutput("cfgWrWaits", 32'(wt), 32'd0);
        apbXfer(1'b0, 8'h10, 8'h00, rd, er, wt);
        checkOutput("wsWaits", 32'(wt), 32'd3);
        checkOutput("wsData", 32'(rd), 32'hA5);

        // Error responses
        apbXfer(1'b0, 8'h80, 8'h00, rd, er, wt);
        checkOutput("unmapErr", 32'(er), 32'd1);
        checkOutput("unmapData", 32'(rd), 32'd0);
        apbXfer(1'b1, 8'hF1, 8'h55, rd, er, wt);
        checkOutput("cntWrErr", 32'(er), 32'd1);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("cntAfterErr", 32'(rd), 32'd5);
        apbXfer(1'b0, 8'hF0, 8'h00, rd, er, wt);
        checkOutput("cfgRead", 32'(rd), 32'd3);

        // Protocol violation in IDLE: immediate error, nothing written
        @(negedge PCLK);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 8'h10;
        PWDATA  = 8'hFF;
        #1;
        checkOutput("violReady", 32'(PREADY), 32'd1);
        checkOutput("violErr", 32'(PSLVERR), 32'd1);
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        apbXfer(1'b0, 8'h10, 8'h00, rd, er, wt);
        checkOutput("violNoWrite", 32'(rd), 32'hA5);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("violCnt", 32'(rd), 32'd8);

        // Abort: PSEL dropped after two waiting ACCESS cycles
        apbXfer(1'b1, 8'hF0, 8'h05, rd, er, wt);
        applyStimulus(1'b1, 8'h20, 8'h3C);
        @(negedge PCLK);
        #1;
        checkOutput("abortAcc1", 32'(PREADY), 32'd0);
        @(negedge PCLK);
        #1;
        checkOutput("abortAcc2", 32'(PREADY), 32'd0);
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        apbXfer(1'b0, 8'h20, 8'h00, rd, er, wt);
        checkOutput("abortWaits", 32'(wt), 32'd5);
        checkOutput("abortData", 32'(rd), 32'd0);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("abortCnt", 32'(rd), 32'd11);

        // Asynchronous reset in the middle of a wait
        applyStimulus(1'b0, 8'h10, 8'h00);
        @(negedge PCLK);
        #2;
        PRST = 1'b0;
        #1;
        checkOutput("midRstReady", 32'(PREADY), 32'd0);
        checkOutput("midRstErr", 32'(PSLVERR), 32'd0);
        checkOutput("midRstData", 32'(PRDATA), 32'd0);
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        PRST = 1'b1;
        apbXfer(1'b0, 8'h10, 8'h00, rd, er, wt);
        checkOutput("midRstReg", 32'(rd), 32'd0);
        checkOutput("midRstWaits", 32'(wt), 32'd0);
        apbXfer(1'b0, 8'hF0, 8'h00, rd, er, wt);
        checkOutput("midRstCfg", 32'(rd), 32'd0);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("midRstCnt", 32'(rd), 32'd2);

        // XFER_CNT wrap: 255 reads, the 256th reads 0xFF, the 257th reads 0
        pulseReset();
        for (int n = 0; n < 255; n++) begin
            apbXfer(1'b0, 8'h00, 8'h00, rd, er, wt);
        end
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("wrapPre", 32'(rd), 32'hFF);
        apbXfer(1'b0, 8'hF1, 8'h00, rd, er, wt);
        checkOutput("wrapZero", 32'(rd), 32'h00);
        checkOutput("wrapErr", 32'(er), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
